// File: rtl/game_sequencer.sv
// Frame-synchronous game controller: IDLE/PLAY/GAME_OVER sequencing, frame/move ticks
// derived from vSync, zombie spawn scheduling and the BCD kill counter.
module game_sequencer #(
    parameter int SPAWN_FRAMES = 120,
    parameter int MOVE_DIV     = 2,
    parameter int NUM_LANES    = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vSync,
    input  logic        btn_start,
    input  logic        zombie_killed,
    input  logic        zombie_reached_house,
    input  logic        spawn_ready,
    output logic        frame_tick,
    output logic        move_tick,
    output logic        spawn_valid,
    output logic [2:0]  spawn_lane,
    output logic [15:0] zombies_killed,
    output logic [1:0]  game_state,
    output logic        game_over
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_OVER = 2'b10;

    localparam int SW = $clog2(SPAWN_FRAMES);
    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_FRAMES - 1);
    localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_DIV - 1);

    logic [1:0]    r_state;
    logic          r_game_over;
    logic          r_vsync_q;
    logic          r_frame_tick;
    logic          r_move_tick;
    logic          r_spawn_valid;
    logic [2:0]    r_spawn_lane;
    logic [15:0]   r_kills;
    logic [SW-1:0] r_spawn_cnt;
    logic [MW-1:0] r_move_cnt;
    logic [7:0]    r_lfsr;

    logic          w_frame_edge;
    logic          w_expire;
    logic          w_xfer;
    logic [2:0]    w_lane;
    logic [15:0]   w_kill_next;
    logic          w_carry;

    assign w_frame_edge = r_vsync_q & ~vSync;
    assign w_expire     = (r_state == S_PLAY) & w_frame_edge & (r_spawn_cnt == SPAWN_LAST);
    // Handshake: a request is transferred on any clk edge that samples spawn_valid
    // and spawn_ready both high; spawn_lane is held constant while spawn_valid is high.
    assign w_xfer       = r_spawn_valid & spawn_ready;
    assign w_lane       = ({1'b0, r_lfsr[2:0]} >= 4'(NUM_LANES)) ?
                          (r_lfsr[2:0] - 3'(NUM_LANES)) : r_lfsr[2:0];

    // Saturating BCD increment with per-digit carry.
    always_comb begin
        w_kill_next = r_kills;
        w_carry     = (r_kills != 16'h9999);
        for (int d = 0; d < 4; d++) begin
            if (w_carry) begin
                if (r_kills[d*4 +: 4] == 4'd9) begin
                    w_kill_next[d*4 +: 4] = 4'd0;
                end else begin
                    w_kill_next[d*4 +: 4] = r_kills[d*4 +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_game_over   <= 1'b0;
            r_vsync_q     <= 1'b1;
            r_frame_tick  <= 1'b0;
            r_move_tick   <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_spawn_lane  <= 3'd0;
            r_kills       <= 16'h0000;
            r_spawn_cnt   <= '0;
            r_move_cnt    <= '0;
            r_lfsr        <= 8'hA5;
        end else begin
            r_vsync_q    <= vSync;
            r_frame_tick <= w_frame_edge;
            r_move_tick  <= 1'b0;
            r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            case (r_state)
                S_IDLE: begin
                    r_spawn_valid <= 1'b0;
                    if (btn_start) begin
                        r_state     <= S_PLAY;
                        r_kills     <= 16'h0000;
                        r_spawn_cnt <= '0;
                        r_move_cnt  <= '0;
                    end
                end
                S_PLAY: begin
                    if (zombie_killed) r_kills <= w_kill_next;
                    if (w_frame_edge) begin
                        if (r_move_cnt == MOVE_LAST) begin
                            r_move_cnt  <= '0;
                            r_move_tick <= 1'b1;
                        end else begin
                            r_move_cnt <= r_move_cnt + 1'b1;
                        end
                        r_spawn_cnt <= (r_spawn_cnt == SPAWN_LAST) ? '0 : r_spawn_cnt + 1'b1;
                    end
                    // Leaving PLAY drops any pending request; an expiry while busy is lost.
                    if (zombie_reached_house) begin
                        r_spawn_valid <= 1'b0;
                        r_state       <= S_OVER;
                        r_game_over   <= 1'b1;
                    end else if (w_expire && (!r_spawn_valid || w_xfer)) begin
                        r_spawn_valid <= 1'b1;
                        r_spawn_lane  <= w_lane;
                    end else if (w_xfer) begin
                        r_spawn_valid <= 1'b0;
                    end
                end
                S_OVER: begin
                    r_spawn_valid <= 1'b0;
                    if (btn_start) begin
                        r_state     <= S_IDLE;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_game_over   <= 1'b0;
                    r_spawn_valid <= 1'b0;
                end
            endcase
        end
    end

    assign frame_tick     = r_frame_tick;
    assign move_tick      = r_move_tick;
    assign spawn_valid    = r_spawn_valid;
    assign spawn_lane     = r_spawn_lane;
    assign zombies_killed = r_kills;
    assign game_state     = r_state;
    assign game_over      = r_game_over;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed phases plus randomized play, scoreboarded
// against a frame-counting behavioural model of the game rules.
module tb_game_sequencer;
  localparam int SPAWN_FRAMES = 120;
  localparam int MOVE_DIV     = 2;
  localparam int NUM_LANES    = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vSync = 1'b1;
  logic        btn_start = 1'b0;
  logic        zombie_killed = 1'b0;
  logic        zombie_reached_house = 1'b0;
  logic        spawn_ready = 1'b0;
  logic        frame_tick;
  logic        move_tick;
  logic        spawn_valid;
  logic [2:0]  spawn_lane;
  logic [15:0] zombies_killed;
  logic [1:0]  game_state;
  logic        game_over;

  game_sequencer #(
    .SPAWN_FRAMES(SPAWN_FRAMES),
    .MOVE_DIV(MOVE_DIV),
    .NUM_LANES(NUM_LANES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vSync(vSync),
    .btn_start(btn_start),
    .zombie_killed(zombie_killed),
    .zombie_reached_house(zombie_reached_house),
    .spawn_ready(spawn_ready),
    .frame_tick(frame_tick),
    .move_tick(move_tick),
    .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane),
    .zombies_killed(zombies_killed),
    .game_state(game_state),
    .game_over(game_over)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  logic [2:0]  exp_lane_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [1:0]  exp_state_q[$];

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] m_lfsr;
  logic       m_vs;
  int         m_state;
  int         m_kills;
  int         m_frames;
  bit         m_pend;
  int         m_move_total = 0;
  int         m_frame_total = 0;
  bit         m_edge, m_expire, m_xfer;
  int         m_cand;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr = 8'hA5; m_vs = 1'b1; m_state = 0; m_kills = 0; m_frames = 0; m_pend = 0;
      exp_lane_q.delete(); exp_cnt_q.delete(); exp_state_q.delete();
    end else begin
      m_edge = m_vs && !vSync;
      m_vs = vSync;
      if (m_edge) m_frame_total++;
      m_cand = m_lfsr % 8;
      if (m_cand >= NUM_LANES) m_cand -= NUM_LANES;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
      m_xfer = m_pend && spawn_ready;
      m_expire = 0;
      case (m_state)
        0: begin
          m_pend = 0;
          if (btn_start) begin
            m_state = 1; exp_state_q.push_back(2'd1);
            if (m_kills != 0) begin m_kills = 0; exp_cnt_q.push_back(16'h0000); end
            m_frames = 0;
          end
        end
        1: begin
          if (zombie_killed && m_kills < 9999) begin
            m_kills++; exp_cnt_q.push_back(to_bcd(m_kills));
          end
          if (m_edge) begin
            m_frames++;
            if (m_frames % MOVE_DIV == 0) m_move_total++;
            if (m_frames % SPAWN_FRAMES == 0) m_expire = 1;
          end
          if (zombie_reached_house) begin
            m_pend = 0; m_state = 2; exp_state_q.push_back(2'd2);
          end else if (m_expire && (!m_pend || m_xfer)) begin
            m_pend = 1; exp_lane_q.push_back(3'(m_cand));
          end else if (m_xfer) begin
            m_pend = 0;
          end
        end
        default: begin
          m_pend = 0;
          if (btn_start) begin m_state = 0; exp_state_q.push_back(2'd0); end
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic        p_valid, p_xfer;
  logic [2:0]  p_lane;
  logic [15:0] p_cnt;
  logic [1:0]  p_state;
  logic [1:0]  e_state;
  int n_frame = 0, n_move = 0, n_req = 0, n_xfer = 0, n_valid_cyc = 0;

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_valid = 0; p_xfer = 0; p_lane = 0; p_cnt = 16'h0000; p_state = 2'd0;
    end else begin
      if (frame_tick) n_frame++;
      if (move_tick) n_move++;
      if (spawn_valid) begin
        n_valid_cyc++;
        if (!p_valid || p_xfer) begin
          n_req++;
          check("lane_range", 32'(spawn_lane <= 3'(NUM_LANES - 1)), 32'd1);
          if (exp_lane_q.size() == 0) check("spawn_unexpected", 32'd1, 32'd0);
          else check("spawn_lane", 32'(spawn_lane), 32'(exp_lane_q.pop_front()));
        end else begin
          check("lane_stable", 32'(spawn_lane), 32'(p_lane));
        end
      end
      if (spawn_valid && spawn_ready) n_xfer++;
      if (zombies_killed !== p_cnt) begin
        if (exp_cnt_q.size() == 0) check("count_unexpected", 32'(zombies_killed), 32'(p_cnt));
        else check("zombies_killed", 32'(zombies_killed), 32'(exp_cnt_q.pop_front()));
      end
      if (game_state !== p_state) begin
        if (exp_state_q.size() == 0) check("state_unexpected", 32'(game_state), 32'(p_state));
        else begin
          e_state = exp_state_q.pop_front();
          check("game_state", 32'(game_state), 32'(e_state));
          check("game_over", 32'(game_over), 32'(e_state == 2'd2));
        end
      end
      p_xfer = spawn_valid && spawn_ready;
      p_valid = spawn_valid; p_lane = spawn_lane; p_cnt = zombies_killed; p_state = game_state;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_frames(input int n);
    for (int f = 0; f < n; f++) begin
      vSync = 1'b0; tick(); tick();
      vSync = 1'b1; repeat (6) tick();
    end
  endtask

  task automatic rand_frames(input int n);
    int lo, hi;
    for (int f = 0; f < n; f++) begin
      lo = $urandom_range(1, 3);
      hi = $urandom_range(3, 8);
      for (int c = 0; c < lo + hi; c++) begin
        vSync = (c >= lo);
        zombie_killed = ($urandom_range(0, 5) == 0);
        spawn_ready = $urandom_range(0, 1);
        tick();
      end
    end
    zombie_killed = 1'b0; spawn_ready = 1'b0; vSync = 1'b1; tick();
  endtask

  task automatic pulse_start();
    btn_start = 1'b1; tick(); btn_start = 1'b0; tick();
  endtask

  task automatic kill_n(input int n);
    zombie_killed = 1'b1; repeat (n) tick(); zombie_killed = 1'b0; tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
    check({tag, "_move_tick"}, 32'(move_tick), 32'd0);
    check({tag, "_spawn_valid"}, 32'(spawn_valid), 32'd0);
    check({tag, "_spawn_lane"}, 32'(spawn_lane), 32'd0);
    check({tag, "_count"}, 32'(zombies_killed), 32'h0000);
    check({tag, "_state"}, 32'(game_state), 32'd0);
    check({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int s_frame, s_move, s_req, s_xfer, s_valid;

  task automatic snap();
    s_frame = n_frame; s_move = n_move; s_req = n_req; s_xfer = n_xfer; s_valid = n_valid_cyc;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1; tick();

    // Reset in the middle of PLAY with a spawn pending.
    pulse_start();
    drive_frames(121);
    check("pre_reset_valid", 32'(spawn_valid), 32'd1);
    check("pre_reset_state", 32'(game_state), 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1; tick();
    snap();
    drive_frames(10);
    check("idle_frames", 32'(n_frame - s_frame), 32'd10);
    check("idle_moves", 32'(n_move - s_move), 32'd0);
    check("idle_valid", 32'(n_valid_cyc - s_valid), 32'd0);

    // Move and spawn cadence with ready held high.
    spawn_ready = 1'b1;
    pulse_start();
    snap();
    drive_frames(240);
    check("cad_moves", 32'(n_move - s_move), 32'd120);
    check("cad_reqs", 32'(n_req - s_req), 32'd2);
    check("cad_width", 32'(n_valid_cyc - s_valid), 32'd2);
    check("cad_xfers", 32'(n_xfer - s_xfer), 32'd2);

    // Backpressure: one request held, later expiries dropped.
    spawn_ready = 1'b0;
    snap();
    drive_frames(300);
    check("bp_reqs", 32'(n_req - s_req), 32'd1);
    check("bp_valid", 32'(spawn_valid), 32'd1);
    spawn_ready = 1'b1; tick(); spawn_ready = 1'b0;
    check("bp_xfer", 32'(n_xfer - s_xfer), 32'd1);
    check("bp_fall", 32'(spawn_valid), 32'd0);
    repeat (10) tick();
    check("bp_no_queue", 32'(spawn_valid), 32'd0);

    // BCD counting and saturation.
    kill_n(10);
    check("bcd_10", 32'(zombies_killed), 32'h0010);
    kill_n(9988);
    check("bcd_9998", 32'(zombies_killed), 32'h9998);
    kill_n(3);
    check("bcd_sat", 32'(zombies_killed), 32'h9999);

    // Game over via simultaneous kill and house reach, then restart.
    zombie_reached_house = 1'b1; tick(); zombie_reached_house = 1'b0; tick();
    check("go1_state", 32'(game_state), 32'd2);
    pulse_start();
    pulse_start();
    check("restart_count", 32'(zombies_killed), 32'h0000);
    kill_n(5);
    check("bcd_5", 32'(zombies_killed), 32'h0005);
    zombie_killed = 1'b1; zombie_reached_house = 1'b1; tick();
    zombie_killed = 1'b0; zombie_reached_house = 1'b0; tick();
    check("go_count", 32'(zombies_killed), 32'h0006);
    check("go_state", 32'(game_state), 32'd2);
    check("go_flag", 32'(game_over), 32'd1);
    kill_n(3);
    check("go_kills_ignored", 32'(zombies_killed), 32'h0006);
    pulse_start();
    check("idle_state", 32'(game_state), 32'd0);
    check("idle_count_held", 32'(zombies_killed), 32'h0006);
    pulse_start();
    check("play_state", 32'(game_state), 32'd1);
    check("play_count_clr", 32'(zombies_killed), 32'h0000);

    // Start pressed mid-PLAY must not disturb anything.
    spawn_ready = 1'b1;
    kill_n(3);
    drive_frames(50);
    pulse_start();
    check("ign_state", 32'(game_state), 32'd1);
    check("ign_count", 32'(zombies_killed), 32'h0003);
    snap();
    drive_frames(69);
    check("ign_no_early", 32'(n_req - s_req), 32'd0);
    drive_frames(1);
    check("ign_on_time", 32'(n_req - s_req), 32'd1);

    // Randomized play.
    rand_frames(300);
    zombie_reached_house = 1'b1; tick(); zombie_reached_house = 1'b0;
    repeat (4) tick();

    check("final_state", 32'(game_state), 32'd2);
    check("move_total", 32'(n_move), 32'(m_move_total));
    check("frame_total", 32'(n_frame), 32'(m_frame_total));
    check("lane_q_empty", 32'(exp_lane_q.size()), 32'd0);
    check("cnt_q_empty", 32'(exp_cnt_q.size()), 32'd0);
    check("state_q_empty", 32'(exp_state_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Frame-synchronous game controller for the plants-vs-zombies VGA datapath. Sits between display_controller (vSync), the pixel/sprite logic (vga_bitchange) and the seven-segment counter.
- Runs the IDLE/PLAY/GAME_OVER state machine and derives per-frame update and move ticks from vSync.
- Schedules zombie spawns to the sprite logic over a valid/ready handshake.
- Keeps the 4-digit BCD kill count that drives counter.displayNumber.

Parameters:
- SPAWN_FRAMES, 120, frames between spawn attempts (≥2).
- MOVE_DIV, 2, frames per zombie step (≥1).
- NUM_LANES, 5, number of lanes (4..8).

Ports:
- clk  in  1  system clock (ClkPort domain).
- reset_n  in  1  asynchronous active-low reset.
- vSync  in  1  active-low vertical sync from display_controller, same clock domain.
- btn_start  in  1  debounced single-cycle start/restart pulse.
- zombie_killed  in  1  single-cycle pulse from sprite logic.
- zombie_reached_house  in  1  single-cycle pulse from sprite logic.
- spawn_ready  in  1  sprite logic accepts spawn request.
- frame_tick  out  1  one-cycle pulse per frame.
- move_tick  out  1  one-cycle pulse every MOVE_DIV frames while in PLAY.
- spawn_valid  out  1  spawn request pending.
- spawn_lane  out  3  lane index of the pending request, 0..NUM_LANES-1.
- zombies_killed  out  16  BCD kill count, {thousands, hundreds, tens, ones}.
- game_state  out  2  00 IDLE, 01 PLAY, 10 GAME_OVER.
- game_over  out  1  high while in GAME_OVER.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - game_state=IDLE, game_over=0.
  - frame_tick=0, move_tick=0.
  - spawn_valid=0, spawn_lane=0.
  - zombies_killed=16'h0000.
  - Frame, move and spawn counters = 0.
  - LFSR = 8'hA5.
  - vSync history register = 1.
- Reset mid-operation: all of the above apply immediately, including with spawn_valid high.
- Frame tick:
  - Register vSync each cycle.
  - frame_tick=1 for exactly one cycle, registered, in the cycle after vSync is first sampled 0 following a 1.
  - Runs in all states.
- State machine:
  - IDLE -> PLAY on btn_start. On this transition, clear zombies_killed, the spawn counter and the move counter.
  - PLAY -> GAME_OVER on zombie_reached_house.
  - GAME_OVER -> IDLE on btn_start.
  - btn_start in PLAY is ignored.
  - State is registered; outputs change the cycle after the triggering pulse.
- Move tick:
  - In PLAY, a move counter counts frame_ticks.
  - When it reaches MOVE_DIV-1 on a frame_tick, it wraps to 0 and move_tick pulses together with that cycle's frame_tick.
  - move_tick is 0 outside PLAY.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clock in every state.
  - Lane candidate = lfsr[2:0]; if ≥NUM_LANES, subtract NUM_LANES.
- Spawn scheduling (PLAY only):
  - The spawn counter increments on frame_tick.
  - On the frame_tick where it equals SPAWN_FRAMES-1, it wraps to 0 and an interval expires.
  - On expiry with spawn_valid=0: next cycle spawn_valid=1 and spawn_lane=lane candidate.
  - On expiry with spawn_valid=1: the interval is dropped; there is no queueing and the pending lane is unchanged.
  - While spawn_valid=1, spawn_lane must be held stable.
  - Transfer occurs when spawn_valid&spawn_ready is sampled high at a clk edge. spawn_valid deasserts the following cycle unless a new expiry lands in that same cycle.
  - spawn_ready while spawn_valid=0 has no effect.
  - Leaving PLAY forces spawn_valid=0 next cycle, with no transfer.
- Kill counter:
  - In PLAY, zombie_killed increments zombies_killed as BCD: per-digit carry at 9->0.
  - Saturates at 16'h9999.
  - Ignored in IDLE/GAME_OVER; the value is held for display.
- Simultaneous events:
  - zombie_killed and zombie_reached_house in the same cycle: count the kill, then go to GAME_OVER.
  - frame_tick and zombie_reached_house in the same cycle: the spawn expiry for that frame is discarded.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset and IDLE:
  - Stimulus: assert reset_n=0 mid-PLAY with spawn_valid=1.
  - Required response: all outputs return to their reset values asynchronously.
  - Then, after release, drive 10 vSync frames: frame_tick pulses 10 times, and move_tick and spawn_valid stay 0.
- Move and spawn cadence:
  - Stimulus: btn_start, then 240 frames with spawn_ready tied 1. Test parameters: MOVE_DIV=2, SPAWN_FRAMES=120.
  - Required response: 120 move_ticks; exactly 2 spawn_valid pulses, each 1 cycle wide; every spawn_lane ≤4.
- Backpressure:
  - Stimulus: spawn_ready=0 for 300 frames.
  - Required response: spawn_valid stays high with spawn_lane constant, and dropped intervals are not queued.
  - Then raise spawn_ready for 1 cycle: exactly one transfer, and spawn_valid falls the next cycle.
- BCD count:
  - Stimulus: 10 zombie_killed pulses.
  - Required response: zombies_killed=16'h0010.
  - Stimulus: preload to 9998, then 3 pulses.
  - Required response: 16'h9999 (saturated).
- Game over and restart:
  - Stimulus: zombie_killed and zombie_reached_house in the same cycle at count 0005.
  - Required response: count=0006, game_state=10, game_over=1, and further kills are ignored.
  - Stimulus: btn_start, then btn_start again.
  - Required response: first -> IDLE with count held at 0006; second -> PLAY with count=0000.
- Start ignored in PLAY:
  - Stimulus: btn_start mid-PLAY at count 0003.
  - Required response: state stays 01, count stays 0003, and the spawn counter is not reset (the next spawn arrives on schedule).
